// File: rtl/morph3x3_filter.sv
// 3x3 morphological erode/dilate over a raster pixel stream, with border padding,
// valid/ready input, frame markers and an end-of-frame flush that drains the last two rows.
module morph3x3_filter #(
    parameter int DATA_W = 10,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int GRAY   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eof
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H + 2);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] FLUSH_ROW = ROW_W'(IMG_H + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             state_r;
    logic [ROW_W-1:0]   row_r;
    logic [COL_W-1:0]   col_r;
    logic               mode_r;
    logic [DATA_W-1:0]  lb1_r [IMG_W];
    logic [DATA_W-1:0]  lb2_r [IMG_W];
    logic [DATA_W-1:0]  win_r [2][3];

    logic               accept_s;
    logic               push_s;
    logic [ROW_W-1:0]   push_row_s;
    logic [COL_W-1:0]   push_col_s;
    logic [DATA_W-1:0]  push_pix_s;
    logic               push_mode_s;
    logic [ROW_W-1:0]   nxt_row_s;
    logic [COL_W-1:0]   nxt_col_s;
    logic [DATA_W-1:0]  lb1_s;
    logic [DATA_W-1:0]  lb2_s;
    logic [DATA_W-1:0]  tap_s [3][3];
    logic               cen_ok_s;
    logic [ROW_W-1:0]   cen_row_s;
    logic [COL_W-1:0]   cen_col_s;
    logic [2:0]         row_ok_s;
    logic [2:0]         col_ok_s;
    logic [DATA_W-1:0]  acc_s;

    function automatic logic [DATA_W-1:0] combine(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic              dilate);
        logic [DATA_W-1:0] r;
        if (GRAY != 0) begin
            if (dilate) begin
                r = (a > b) ? a : b;
            end else begin
                r = (a < b) ? a : b;
            end
        end else begin
            if (dilate) begin
                r = a | b;
            end else begin
                r = a & b;
            end
        end
        return r;
    endfunction

    assign accept_s = in_valid & in_ready;
    assign lb1_s    = lb1_r[push_col_s];
    assign lb2_s    = lb2_r[push_col_s];

    // Decide whether this cycle pushes a column and at which frame coordinate.
    always_comb begin
        push_s      = 1'b0;
        push_row_s  = row_r;
        push_col_s  = col_r;
        push_pix_s  = in_data;
        push_mode_s = mode_r;
        case (state_r)
            S_IDLE, S_RUN: begin
                if (accept_s && in_sof) begin
                    push_s      = 1'b1;
                    push_row_s  = '0;
                    push_col_s  = '0;
                    push_mode_s = mode;
                end else if (accept_s && (state_r == S_RUN)) begin
                    push_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            S_FLUSH: begin
                push_s     = 1'b1;
                push_pix_s = '0;
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    // Raster position following the current push.
    always_comb begin
        if (push_col_s == LAST_COL) begin
            nxt_col_s = '0;
            nxt_row_s = push_row_s + ROW_W'(1);
        end else begin
            nxt_col_s = push_col_s + COL_W'(1);
            nxt_row_s = push_row_s;
        end
    end

    // Frame control: idle/run/flush sequencing, raster counters, latched mode, in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            row_r    <= '0;
            col_r    <= '0;
            mode_r   <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            mode_r <= push_mode_s;
            case (state_r)
                S_IDLE: begin
                    if (push_s) begin
                        state_r <= S_RUN;
                        row_r   <= nxt_row_s;
                        col_r   <= nxt_col_s;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (push_s) begin
                        row_r <= nxt_row_s;
                        col_r <= nxt_col_s;
                        if (!in_sof && (push_row_s == LAST_ROW) && (push_col_s == LAST_COL)) begin
                            state_r  <= S_FLUSH;
                            in_ready <= 1'b0;
                        end else begin
                            state_r <= S_RUN;
                        end
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_FLUSH: begin
                    if (push_row_s == FLUSH_ROW) begin
                        state_r  <= S_IDLE;
                        in_ready <= 1'b1;
                        row_r    <= '0;
                        col_r    <= '0;
                    end else begin
                        row_r <= nxt_row_s;
                        col_r <= nxt_col_s;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    in_ready <= 1'b1;
                    row_r    <= '0;
                    col_r    <= '0;
                end
            endcase
        end
    end

    // Line buffers: line 1 holds the previous row, line 2 the one before it.
    always_ff @(posedge clk) begin
        if (push_s) begin
            lb1_r[push_col_s] <= push_pix_s;
            lb2_r[push_col_s] <= lb1_s;
        end
    end

    // Two stored window columns; the newest column is taken straight from the push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_r[0] <= '{default: '0};
            win_r[1] <= '{default: '0};
        end else if (push_s) begin
            win_r[0]    <= win_r[1];
            win_r[1][0] <= lb2_s;
            win_r[1][1] <= lb1_s;
            win_r[1][2] <= push_pix_s;
        end else begin
            win_r <= win_r;
        end
    end

    // Assemble the 3x3 taps: [column][row], top row first.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tap_s[0][i] = win_r[0][i];
            tap_s[1][i] = win_r[1][i];
        end
        tap_s[2][0] = lb2_s;
        tap_s[2][1] = lb1_s;
        tap_s[2][2] = push_pix_s;
    end

    // A column-0 push closes the previous row's last pixel, two rows back.
    always_comb begin
        cen_ok_s  = 1'b0;
        cen_row_s = '0;
        cen_col_s = '0;
        if (push_col_s == '0) begin
            cen_col_s = LAST_COL;
            if (push_row_s >= ROW_W'(2)) begin
                cen_ok_s  = push_s;
                cen_row_s = push_row_s - ROW_W'(2);
            end else begin
                cen_ok_s = 1'b0;
            end
        end else begin
            cen_col_s = push_col_s - COL_W'(1);
            if (push_row_s >= ROW_W'(1)) begin
                cen_ok_s  = push_s;
                cen_row_s = push_row_s - ROW_W'(1);
            end else begin
                cen_ok_s = 1'b0;
            end
        end
    end

    assign row_ok_s = {cen_row_s != LAST_ROW, 1'b1, cen_row_s != '0};
    assign col_ok_s = {cen_col_s != LAST_COL, 1'b1, cen_col_s != '0};

    // Reduce the in-frame taps, starting from the operator's identity value.
    always_comb begin
        acc_s = push_mode_s ? {DATA_W{1'b0}} : {DATA_W{1'b1}};
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 3; i++) begin
                if (row_ok_s[i] && col_ok_s[j]) begin
                    acc_s = combine(acc_s, tap_s[j][i], push_mode_s);
                end else begin
                    acc_s = acc_s;
                end
            end
        end
    end

    // Registered output stage; data holds its last value between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (cen_ok_s) begin
            out_data  <= acc_s;
            out_valid <= 1'b1;
            out_sof   <= (cen_row_s == '0) && (cen_col_s == '0);
            out_eof   <= (cen_row_s == LAST_ROW) && (cen_col_s == LAST_COL);
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_morph3x3_filter.sv
// Directed bench for morph3x3_filter on an 8x6 frame: a binary (GRAY=0) and a grayscale
// (GRAY=1) instance share the stimulus; outputs are collected and compared to closed forms.
module tb_morph3x3_filter;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          rdy_b, rdy_g, ov_b, ov_g, os_b, os_g, oe_b, oe_g;
    logic [DW-1:0] od_b, od_g;
    logic [11:0]   bq[$];
    logic [11:0]   gq[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            n_fail = 0;
    int            stall;

    always #5 clk = ~clk;

    morph3x3_filter #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .GRAY(0)) u_bin (
        .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(rdy_b), .out_data(od_b), .out_valid(ov_b),
        .out_sof(os_b), .out_eof(oe_b));

    morph3x3_filter #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .GRAY(1)) u_gray (
        .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(rdy_g), .out_data(od_g), .out_valid(ov_g),
        .out_sof(os_g), .out_eof(oe_g));

    always @(negedge clk) begin
        if (ov_b) bq.push_back({oe_b, os_b, od_b});
        if (ov_g) gq.push_back({oe_g, os_g, od_g});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] in_px(input int t, input int r, input int c);
        case (t)
            1:       return (r == 2 && c == 3) ? 10'h000 : 10'h3FF;
            2:       return (r == 0 && c == 0) ? 10'h3FF : 10'h000;
            default: return DW'(r * 8 + c);
        endcase
    endfunction

    function automatic logic [DW-1:0] exp_px(input int t, input logic m, input int r, input int c);
        int rr, cc;
        case (t)
            1: return (r >= 1 && r <= 3 && c >= 2 && c <= 4) ? 10'h000 : 10'h3FF;
            2: return (r <= 1 && c <= 1) ? 10'h3FF : 10'h000;
            default: begin
                if (m) begin
                    rr = (r + 1 > 5) ? 5 : r + 1;
                    cc = (c + 1 > 7) ? 7 : c + 1;
                end else begin
                    rr = (r - 1 < 0) ? 0 : r - 1;
                    cc = (c - 1 < 0) ? 0 : c - 1;
                end
                return DW'(rr * 8 + cc);
            end
        endcase
    endfunction

    function automatic int qsize(input bit g);
        return g ? gq.size() : bq.size();
    endfunction

    // Hold one pixel until accepted; returns the number of cycles in_ready stayed low.
    task automatic push_px(input logic [DW-1:0] d, input logic s, output int stalls);
        stalls = 0;
        in_data = d;
        in_sof = s;
        in_valid = 1'b1;
        while (!rdy_b && stalls < 100) begin
            @(posedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 100) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic send_frame(input int t, input logic m, input int npix, output int first_stall);
        int s;
        mode = m;
        for (int i = 0; i < npix; i++) begin
            push_px(in_px(t, i / W, i % W), i == 0, s);
            if (i == 0) begin
                first_stall = s;
                mode = ~m;
            end
        end
    endtask

    task automatic wait_out(input bit g, input int n, input string tag);
        for (int k = 0; k < 300 && qsize(g) < n; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_count"}, qsize(g), n);
    endtask

    task automatic verify(input bit g, input int t, input logic m, input int off, input string tag);
        int bad = 0, sof_bad = 0, eof_bad = 0;
        logic [11:0] e;
        for (int i = 0; i < W * H; i++) begin
            if (off + i >= qsize(g)) begin
                bad++;
            end else begin
                e = g ? gq[off + i] : bq[off + i];
                if (e[9:0] !== exp_px(t, m, i / W, i % W)) begin
                    if (bad == 0) $display("%s first diff at %0d: %h vs %h", tag, i, e[9:0], exp_px(t, m, i / W, i % W));
                    bad++;
                end
                if (e[10] !== (i == 0)) sof_bad++;
                if (e[11] !== (i == W * H - 1)) eof_bad++;
            end
        end
        check({tag, "_data"}, bad, 0);
        check({tag, "_sof"}, sof_bad, 0);
        check({tag, "_eof"}, eof_bad, 0);
    endtask

    initial begin
        int eofs;
        #12;
        check("rst_valid", ov_b, 1'b0);
        check("rst_data", od_b, 10'h000);
        check("rst_sof_eof", {os_b, oe_b}, 2'b00);
        check("rst_ready", {rdy_b, rdy_g}, 2'b11);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: binary erode, single hole
        bq.delete(); gq.delete();
        send_frame(1, 1'b0, W * H, stall);
        wait_out(0, W * H, "t1");
        verify(0, 1, 1'b0, 0, "t1");

        // 2: binary dilate, single bright corner pixel
        bq.delete(); gq.delete();
        send_frame(2, 1'b1, W * H, stall);
        wait_out(0, W * H, "t2");
        verify(0, 2, 1'b1, 0, "t2");

        // 3: grayscale ramp, erode then dilate
        bq.delete(); gq.delete();
        send_frame(3, 1'b0, W * H, stall);
        wait_out(1, W * H, "t3e");
        verify(1, 3, 1'b0, 0, "t3e");
        gq.delete();
        send_frame(3, 1'b1, W * H, stall);
        wait_out(1, W * H, "t3d");
        verify(1, 3, 1'b1, 0, "t3d");

        // 4: back-to-back frames, mode toggled mid-frame
        bq.delete(); gq.delete();
        send_frame(3, 1'b0, W * H, stall);
        send_frame(3, 1'b1, W * H, stall);
        check("t4_stall", stall, W + 1);
        stall = 0;
        in_valid = 1'b1;
        while (!rdy_b && stall < 100) begin
            @(posedge clk);
            #1;
            stall++;
        end
        in_valid = 1'b0;
        check("t4_stall2", stall, W + 1);
        wait_out(1, 2 * W * H, "t4");
        verify(1, 3, 1'b0, 0, "t4a");
        verify(1, 3, 1'b1, W * H, "t4b");
        bq.delete(); gq.delete();

        // 5: abort after 20 pixels; aborted part yields 11 centres, none with eof
        send_frame(1, 1'b0, 20, stall);
        send_frame(1, 1'b0, W * H, stall);
        wait_out(0, 11 + W * H, "t5");
        eofs = 0;
        for (int i = 0; i < 11 && i < bq.size(); i++) eofs += int'(bq[i][11]);
        check("t5_abort_eof", eofs, 0);
        verify(0, 1, 1'b0, 11, "t5");

        // 6: reset mid-run, then pixels without sof are dropped
        bq.delete(); gq.delete();
        send_frame(1, 1'b0, 15, stall);
        check("t6_pre_valid", ov_b, 1'b1);
        check("t6_pre_data", od_b, 10'h3FF);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", ov_b, 1'b0);
        check("t6_rst_data", od_b, 10'h000);
        check("t6_rst_ready", rdy_b, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        bq.delete(); gq.delete();
        for (int i = 0; i < 5; i++) push_px(10'h3FF, 1'b0, stall);
        repeat (5) @(posedge clk);
        #1;
        check("t6_dropped", bq.size(), 0);
        send_frame(2, 1'b1, W * H, stall);
        wait_out(0, W * H, "t6");
        verify(0, 2, 1'b1, 0, "t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
